// File: rtl/trim_gpio_banked.sv
// trim_gpio_banked: double-buffered per-channel gain trim using one time-shared multiplier
module trim_gpio_banked #(
  parameter int GPIO_WIDTH = 32,
  parameter int NUM_GAINS  = 4,
  parameter int MAG_WIDTH  = 26,
  parameter int GAIN_WIDTH = 27,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [GPIO_WIDTH-1:0]          gpioData,
  input  logic [ADDR_WIDTH-1:0]          gainAddr,
  input  logic                           gainStrobe,
  input  logic                           commitStrobe,
  input  logic                           rbkShadow,
  input  logic                           statusClear,
  output logic [GPIO_WIDTH-1:0]          gainRBK,
  output logic [NUM_GAINS+2:0]           status,
  input  logic                           strobe,
  input  logic [MAG_WIDTH*NUM_GAINS-1:0] magnitudes,
  output logic                           trimmedToggle,
  output logic                           trimmedStrobe,
  output logic [MAG_WIDTH*NUM_GAINS-1:0] trimmed
);
  typedef enum logic [1:0] {IDLE, MUL, DRAIN} state_t;
  localparam int PW = MAG_WIDTH + GAIN_WIDTH;
  localparam int NB = 2 ** ADDR_WIDTH;
  localparam logic [GAIN_WIDTH-1:0] UNITY = {1'b1, {(GAIN_WIDTH-1){1'b0}}};
  localparam logic [ADDR_WIDTH:0] NG = (ADDR_WIDTH+1)'(NUM_GAINS);
  localparam logic [ADDR_WIDTH-1:0] KL = ADDR_WIDTH'(NUM_GAINS-1);
  localparam logic [MAG_WIDTH-1:0] MMAX = '1;
  state_t state, state_n;
  logic act, bank_l, pending, overrun, v1, last2, swap, addr_ok, sat_now;
  logic [ADDR_WIDTH-1:0] k, k1;
  logic [GAIN_WIDTH-1:0] bank [2][NB];
  logic [MAG_WIDTH*NUM_GAINS-1:0] mag_l, res;
  logic [NUM_GAINS-1:0] satf;
  logic [PW-1:0] p1;
  logic [PW:0] rsum;
  logic [MAG_WIDTH+1:0] rq;
  logic [MAG_WIDTH-1:0] r_sat;
  assign status = {pending, overrun, state != IDLE, satf};
  // A commit is only honoured outside MUL; a commit seen in MUL is held until DRAIN ends.
  always_comb begin
    swap = (state == IDLE && commitStrobe) || (state == DRAIN && (pending || commitStrobe));
    addr_ok = {1'b0, gainAddr} < NG;
    rsum = (PW+1)'(p1) + (PW+1)'(2 ** (GAIN_WIDTH-2));
    rq = (MAG_WIDTH+2)'(rsum >> (GAIN_WIDTH-1));
    sat_now = |rq[MAG_WIDTH+1:MAG_WIDTH];
    r_sat = sat_now ? MMAX : rq[MAG_WIDTH-1:0];
    state_n = state == IDLE ? (strobe ? MUL : IDLE) : state == MUL ? (k == KL ? DRAIN : MUL) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NB; i++) bank[b][i] <= UNITY;
      act <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
      satf <= '0;
      k <= '0;
      k1 <= '0;
      bank_l <= 1'b0;
      v1 <= 1'b0;
      last2 <= 1'b0;
      p1 <= '0;
      mag_l <= '0;
      res <= '0;
      trimmed <= '0;
      trimmedToggle <= 1'b0;
      trimmedStrobe <= 1'b0;
      gainRBK <= '0;
    end else begin
      if (gainStrobe && addr_ok) bank[~act][gainAddr] <= GAIN_WIDTH'(gpioData);
      if (swap) act <= ~act;
      pending <= swap ? 1'b0 : pending | (state == MUL && commitStrobe);
      if (state == IDLE && strobe) begin
        mag_l <= magnitudes;
        bank_l <= act ^ swap;
      end
      k <= state == MUL ? k + 1'b1 : '0;
      v1 <= state == MUL;
      k1 <= k;
      p1 <= PW'(mag_l[k*MAG_WIDTH +: MAG_WIDTH]) * PW'(bank[bank_l][k]);
      if (v1) res[k1*MAG_WIDTH +: MAG_WIDTH] <= r_sat;
      last2 <= v1 && k1 == KL;
      trimmedStrobe <= last2;
      if (last2) begin
        trimmed <= res;
        trimmedToggle <= ~trimmedToggle;
      end
      overrun <= (strobe && state != IDLE) | (overrun & ~statusClear);
      for (int i = 0; i < NUM_GAINS; i++)
        satf[i] <= (v1 && sat_now && k1 == ADDR_WIDTH'(i)) | (satf[i] & ~statusClear);
      gainRBK <= addr_ok ? GPIO_WIDTH'(bank[rbkShadow ? ~act : act][gainAddr]) : '0;
    end
  end
endmodule

// File: tb/tb_trim_gpio_banked.sv
// tb_trim_gpio_banked: randomized self-checking bench with an arithmetic gain-bank model
module tb_trim_gpio_banked;
  localparam int N = 4, MW = 26, GW = 27, AW = 3, DW = 32;
  localparam logic [26:0] UNITY = 27'h4000000, HALF = 27'h2000000;
  logic clk = 0, rst = 1;
  logic [DW-1:0] gpioData = 0;
  logic [AW-1:0] gainAddr = 0;
  logic gainStrobe = 0, commitStrobe = 0, rbkShadow = 0, statusClear = 0, strobe = 0;
  logic [MW*N-1:0] magnitudes = 0;
  logic [DW-1:0] gainRBK;
  logic [N+2:0] status;
  logic trimmedToggle, trimmedStrobe;
  logic [MW*N-1:0] trimmed;
  int checks = 0, errors = 0;
  logic [26:0] mb [2][N];
  int mact = 0;
  logic [MW*N-1:0] last_out = 0;

  trim_gpio_banked #(.GPIO_WIDTH(DW), .NUM_GAINS(N), .MAG_WIDTH(MW), .GAIN_WIDTH(GW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .gpioData(gpioData), .gainAddr(gainAddr), .gainStrobe(gainStrobe),
    .commitStrobe(commitStrobe), .rbkShadow(rbkShadow), .statusClear(statusClear), .gainRBK(gainRBK),
    .status(status), .strobe(strobe), .magnitudes(magnitudes), .trimmedToggle(trimmedToggle),
    .trimmedStrobe(trimmedStrobe), .trimmed(trimmed));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) mb[b][i] = UNITY;
    mact = 0;
  endfunction

  // Expected sample: real-valued gain m*g/2^26, rounded half up, clamped to 26 bits.
  function automatic logic [MW*N-1:0] exp_vec(input logic [MW*N-1:0] m, input int b, output logic [N-1:0] s);
    logic [MW*N-1:0] o;
    longint unsigned p, r;
    for (int i = 0; i < N; i++) begin
      p = longint'(m[i*MW +: MW]) * longint'(mb[b][i]);
      r = (p + 64'd33554432) / 64'd67108864;
      s[i] = r > 64'h3FFFFFF;
      o[i*MW +: MW] = s[i] ? 26'h3FFFFFF : r[25:0];
    end
    return o;
  endfunction

  function automatic logic [MW*N-1:0] rmags();
    logic [MW*N-1:0] m;
    for (int i = 0; i < N; i++) m[i*MW +: MW] = 26'($urandom_range(0, 26'h3FFFFFF));
    return m;
  endfunction

  function automatic logic [MW*N-1:0] fill(input logic [25:0] v);
    return {N{v}};
  endfunction

  task automatic write_gain(input int a, input logic [31:0] v);
    gainAddr = AW'(a);
    gpioData = v;
    gainStrobe = 1;
    step();
    gainStrobe = 0;
    if (a < N) mb[1-mact][a] = v[26:0];
  endtask

  task automatic commit_idle();
    commitStrobe = 1;
    step();
    commitStrobe = 0;
    mact = 1 - mact;
  endtask

  task automatic rd(input int a, input logic sh, output logic [31:0] v);
    gainAddr = AW'(a);
    rbkShadow = sh;
    step();
    v = gainRBK;
  endtask

  task automatic clear_status();
    statusClear = 1;
    step();
    statusClear = 0;
  endtask

  task automatic run_sample(input logic [MW*N-1:0] m, output int lat, output logic [MW*N-1:0] o);
    magnitudes = m;
    strobe = 1;
    step();
    strobe = 0;
    lat = 0;
    o = 'x;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (trimmedStrobe) begin
        o = trimmed;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int lat;
    logic [MW*N-1:0] o, m;
    rst = 1;
    model_reset();
    repeat (3) step();
    rst = 0;
    step();
    checks++; if (status !== 0) begin errors++; $display("FAIL reset_status got %h want 0", status); end
    checks++; if (trimmed !== 0) begin errors++; $display("FAIL reset_trimmed got %h want 0", trimmed); end
    checks++; if (trimmedToggle !== 0 || trimmedStrobe !== 0) begin errors++; $display("FAIL reset_tog_stb got %b%b want 00", trimmedToggle, trimmedStrobe); end
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < N; a++) begin
        rd(a, s[0], v);
        checks++; if (v !== 32'h4000000) begin errors++; $display("FAIL reset_rbk ch%0d sh%0d got %h want 4000000", a, s, v); end
      end
    m = {26'd4000, 26'd3000, 26'd2000, 26'd1000};
    run_sample(m, lat, o);
    checks++; if (lat !== N + 2) begin errors++; $display("FAIL unity_latency got %0d want %0d", lat, N + 2); end
    checks++; if (o !== m) begin errors++; $display("FAIL unity_out got %h want %h", o, m); end
    checks++; if (trimmedToggle !== 1) begin errors++; $display("FAIL unity_toggle got %b want 1", trimmedToggle); end
    step();
    checks++; if (trimmedStrobe !== 0) begin errors++; $display("FAIL unity_strobe_width got %b want 0", trimmedStrobe); end
    last_out = m;
  endtask

  task automatic test_shadow_write();
    logic [31:0] v;
    logic [N-1:0] s;
    int lat;
    logic [MW*N-1:0] o, e;
    for (int a = 0; a < N; a++) write_gain(a, HALF);
    rd(1, 0, v);
    checks++; if (v !== 32'h4000000) begin errors++; $display("FAIL shadow_active_rbk got %h want 4000000", v); end
    rd(1, 1, v);
    checks++; if (v !== 32'h2000000) begin errors++; $display("FAIL shadow_rbk got %h want 2000000", v); end
    checks++; if (trimmed !== last_out) begin errors++; $display("FAIL shadow_out_held got %h want %h", trimmed, last_out); end
    commit_idle();
    run_sample(fill(26'd1000), lat, o);
    e = exp_vec(fill(26'd1000), mact, s);
    checks++; if (o !== fill(26'd500) || o !== e) begin errors++; $display("FAIL half_1000 got %h want %h", o, fill(26'd500)); end
    run_sample(fill(26'd3), lat, o);
    checks++; if (o !== fill(26'd2)) begin errors++; $display("FAIL half_round got %h want %h", o, fill(26'd2)); end
  endtask

  task automatic test_commit_busy();
    logic [N-1:0] s;
    logic [MW*N-1:0] o, m;
    int lat;
    for (int a = 0; a < N; a++) write_gain(a, UNITY);
    commit_idle();
    for (int a = 0; a < N; a++) write_gain(a, HALF);
    m = rmags();
    magnitudes = m;
    strobe = 1;
    step();
    strobe = 0;
    step();
    commitStrobe = 1;
    step();
    commitStrobe = 0;
    checks++; if (status[N+2] !== 1 || status[N] !== 1) begin errors++; $display("FAIL pend_busy got %b want pending&busy", status); end
    o = 'x;
    for (int i = 0; i < 20; i++) begin
      step();
      if (trimmedStrobe) begin o = trimmed; break; end
    end
    checks++; if (o !== m) begin errors++; $display("FAIL pend_old_gain got %h want %h", o, m); end
    checks++; if (status[N+2] !== 0) begin errors++; $display("FAIL pend_cleared got %b want 0", status[N+2]); end
    mact = 1 - mact;
    m = rmags();
    run_sample(m, lat, o);
    checks++; if (o !== exp_vec(m, mact, s)) begin errors++; $display("FAIL pend_new_gain got %h want %h", o, exp_vec(m, mact, s)); end
  endtask

  task automatic test_saturation();
    logic [N-1:0] s;
    logic [MW*N-1:0] o, m, e;
    int lat;
    for (int a = 0; a < N; a++) write_gain(a, a == 2 ? 32'h7FFFFFF : $urandom_range(0, UNITY));
    commit_idle();
    clear_status();
    m = rmags();
    m[2*MW +: MW] = 26'h3FFFFFF;
    run_sample(m, lat, o);
    e = exp_vec(m, mact, s);
    checks++; if (o !== e || o[2*MW +: MW] !== 26'h3FFFFFF) begin errors++; $display("FAIL sat_out got %h want %h", o, e); end
    checks++; if (status[N-1:0] !== 4'b0100) begin errors++; $display("FAIL sat_flags got %b want 0100", status[N-1:0]); end
    clear_status();
    checks++; if (status[N-1:0] !== 0) begin errors++; $display("FAIL sat_clear got %b want 0", status[N-1:0]); end
    magnitudes = m;
    strobe = 1;
    step();
    strobe = 0;
    repeat (3) step();
    statusClear = 1;
    step();
    statusClear = 0;
    checks++; if (status[2] !== 1) begin errors++; $display("FAIL sat_set_wins got %b want 1", status[2]); end
    repeat (4) step();
    clear_status();
  endtask

  task automatic test_overrun();
    logic [N-1:0] s;
    logic [MW*N-1:0] o, ma, mb2, ea;
    int cnt, lat;
    ma = rmags();
    mb2 = rmags();
    ea = exp_vec(ma, mact, s);
    magnitudes = ma;
    strobe = 1;
    step();
    strobe = 0;
    repeat (2) step();
    magnitudes = mb2;
    strobe = 1;
    step();
    strobe = 0;
    cnt = 0;
    o = 'x;
    for (int i = 0; i < 12; i++) begin
      step();
      if (trimmedStrobe) begin cnt++; o = trimmed; end
    end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL ovr_strobes got %0d want 1", cnt); end
    checks++; if (o !== ea) begin errors++; $display("FAIL ovr_out got %h want %h", o, ea); end
    checks++; if (status[N+1] !== 1) begin errors++; $display("FAIL ovr_flag got %b want 1", status[N+1]); end
    clear_status();
    checks++; if (status[N+1] !== 0) begin errors++; $display("FAIL ovr_clear got %b want 0", status[N+1]); end
    magnitudes = ma;
    strobe = 1;
    step();
    strobe = 0;
    repeat (5) step();
    magnitudes = mb2;
    strobe = 1;
    step();
    strobe = 0;
    checks++; if (trimmedStrobe !== 1 || trimmed !== ea) begin errors++; $display("FAIL b2b_first got %b/%h want 1/%h", trimmedStrobe, trimmed, ea); end
    lat = 0;
    o = 'x;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (trimmedStrobe) begin o = trimmed; break; end
    end
    checks++; if (lat !== N + 2 || o !== exp_vec(mb2, mact, s)) begin errors++; $display("FAIL b2b_second got %0d/%h want %0d/%h", lat, o, N + 2, exp_vec(mb2, mact, s)); end
    checks++; if (status[N+1] !== 0) begin errors++; $display("FAIL b2b_no_overrun got %b want 0", status[N+1]); end
  endtask

  task automatic test_random();
    logic [N-1:0] s;
    logic [MW*N-1:0] o, m, e;
    logic [31:0] v;
    int lat, a;
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < N; c++) write_gain(c, $urandom_range(0, 27'h7FFFFFF));
      commit_idle();
      clear_status();
      m = rmags();
      run_sample(m, lat, o);
      e = exp_vec(m, mact, s);
      checks++; if (o !== e) begin errors++; $display("FAIL rand_out it%0d got %h want %h", it, o, e); end
      checks++; if (status[N-1:0] !== s) begin errors++; $display("FAIL rand_sat it%0d got %b want %b", it, status[N-1:0], s); end
      a = $urandom_range(0, N - 1);
      rd(a, 0, v);
      checks++; if (v !== {5'd0, mb[mact][a]}) begin errors++; $display("FAIL rand_rbk it%0d got %h want %h", it, v, mb[mact][a]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int cnt;
    write_gain(0, 32'h1234567);
    commit_idle();
    magnitudes = rmags();
    strobe = 1;
    step();
    strobe = 0;
    step();
    rst = 1;
    #1;
    checks++; if (trimmed !== 0 || status !== 0 || trimmedToggle !== 0 || gainRBK !== 0) begin errors++; $display("FAIL rst_async got %h/%b/%b/%h want zeros", trimmed, status, trimmedToggle, gainRBK); end
    step();
    rst = 0;
    model_reset();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (trimmedStrobe) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL rst_no_strobe got %0d want 0", cnt); end
    write_gain(5, 32'h0000123);
    rd(5, 1, v);
    checks++; if (v !== 0) begin errors++; $display("FAIL oob_rbk got %h want 0", v); end
    for (int sh = 0; sh < 2; sh++)
      for (int a = 0; a < N; a++) begin
        rd(a, sh[0], v);
        checks++; if (v !== {5'd0, mb[sh == 0 ? mact : 1 - mact][a]}) begin errors++; $display("FAIL rst_bank ch%0d sh%0d got %h want 4000000", a, sh, v); end
      end
  endtask

  initial begin
    test_reset();
    test_shadow_write();
    test_commit_busy();
    test_saturation();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trim_gpio_banked.md
Name: trim_gpio_banked

Overview:
Multichannel gain-compensation block with double-buffered (shadow/active) gain banks written over the processor GPIO bus.
- Processor writes gains one channel at a time into the shadow bank, then commits; the swap occurs only at a sample boundary.
- Each magnitude sample is trimmed by a single time-shared multiplier, one channel per cycle, with rounding and saturation.
- Sits between the magnitude/RMS stage and the position calculation, replacing the per-channel parallel trim.

Parameters:
GPIO_WIDTH, 32, processor data bus width.
NUM_GAINS, 4, number of channels (2..16).
MAG_WIDTH, 26, unsigned magnitude width.
GAIN_WIDTH, 27, unsigned gain width, format 1.(GAIN_WIDTH-1); unity = 2^(GAIN_WIDTH-1); must be <= GPIO_WIDTH.
ADDR_WIDTH, 2, channel address width; must satisfy 2^ADDR_WIDTH >= NUM_GAINS.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
gpioData  input  GPIO_WIDTH  write data; gain taken from bits [GAIN_WIDTH-1:0]
gainAddr  input  ADDR_WIDTH  channel selected for write and readback
gainStrobe  input  1  write gpioData to shadow[gainAddr]
commitStrobe  input  1  request shadow/active swap
rbkShadow  input  1  readback source: 1 = shadow bank, 0 = active bank
statusClear  input  1  clear sticky flags
gainRBK  output  GPIO_WIDTH  registered readback, zero-extended gain
status  output  NUM_GAINS+3  {commitPending, overrun, busy, satFlags[NUM_GAINS-1:0]}
strobe  input  1  new magnitude sample valid
magnitudes  input  MAG_WIDTH*NUM_GAINS  channel k at [k*MAG_WIDTH +: MAG_WIDTH]
trimmedToggle  output  1  toggles once per completed sample
trimmedStrobe  output  1  one-cycle pulse per completed sample
trimmed  output  MAG_WIDTH*NUM_GAINS  trimmed magnitudes, same packing as input

Behaviour:
Reset (async, active-high):
- Both banks = unity in every channel; active bank = 0.
- trimmed = 0, trimmedToggle = 0, trimmedStrobe = 0, gainRBK = 0, all status bits = 0.
- FSM returns to IDLE; an in-flight sample is discarded and produces no output.

Writes:
- gainStrobe writes the bank not currently active.
- gainAddr >= NUM_GAINS: write ignored; readback of that address returns 0.

Commit:
- In IDLE: swap takes effect at the next edge.
- In BUSY: commitPending is set; swap occurs on the cycle the FSM returns to IDLE; commitPending clears on the swap.
- Repeated commits while pending collapse into one swap.
- Commit and strobe on the same IDLE cycle: swap applies first, so the new sample uses the new gains.
- The bank used for a sample is frozen at latch time.

Readback: gainRBK updates one cycle after gainAddr/rbkShadow change, or after a write or swap.

FSM:
- IDLE: strobe latches magnitudes and the bank index -> MUL with channel index k = 0.
- MUL: one channel per cycle, k = 0..NUM_GAINS-1, through a 2-stage pipeline (multiply register, round/saturate register) -> DRAIN.
- DRAIN: flush pipeline -> IDLE.
- busy = 1 in MUL and DRAIN.
- Latency: strobe sampled at edge 0; trimmed, trimmedToggle flip and trimmedStrobe = 1 all appear at edge NUM_GAINS+2; trimmedStrobe returns to 0 at edge NUM_GAINS+3.
- All channels of trimmed update simultaneously; there are no partial updates.
- Back-to-back strobes are accepted on the first IDLE cycle, giving a minimum period of NUM_GAINS+2 cycles.

Overrun:
- strobe while busy: sample dropped, overrun sticky set, current computation unaffected.

Arithmetic:
- Product = mag * gain, unsigned, MAG_WIDTH+GAIN_WIDTH bits.
- Result = (product + 2^(GAIN_WIDTH-2)) >> (GAIN_WIDTH-1), i.e. round half up.
- Result > 2^MAG_WIDTH-1: output clamps to 2^MAG_WIDTH-1 and satFlags[k] is set (sticky).
- Gain 0 gives output 0.

statusClear:
- Clears overrun and satFlags.
- A set event on the same cycle wins, so the flag stays set.
- Does not affect busy or commitPending.

Test Plan:
1. Reset -> all 4 channels read 0x4000000 from both banks; magnitudes {1000, 2000, 3000, 4000} with strobe -> trimmed equals input exactly at edge 6; trimmedStrobe high one cycle; trimmedToggle = 1.
2. Write 0x2000000 to shadow ch0..3 without commit -> active readback still 0x4000000 and output unchanged; commit, then magnitude 1000 -> 500 on every channel; magnitude 3 -> 2 (rounding 1.5 up).
3. Commit issued 2 cycles after strobe, with the new bank at gain 0.5 -> current sample uses unity; commitPending = 1 until IDLE; the next sample uses 0.5.
4. Magnitude 0x3FFFFFF with gain 0x7FFFFFF on ch2 -> trimmed ch2 = 0x3FFFFFF, satFlags = 0b0100; statusClear -> 0.
5. Second strobe 3 cycles after the first -> dropped, overrun = 1, exactly one trimmedStrobe; a strobe at the first IDLE cycle (6 cycles after) -> accepted, overrun not set.
6. rst asserted during MUL -> outputs and status go to 0 immediately, active bank = 0, both banks unity, no trimmedStrobe; a gainAddr = 5 write with NUM_GAINS = 4, ADDR_WIDTH = 3 -> no bank changes.
